// File: rtl/inv_sub_bytes_iter.sv
`default_nettype none
// ============================================================================
//  Module   : inv_sub_bytes_iter
//  Brief    : Iterative AES InvSubBytes stage. Substitutes LANES bytes of a
//             128-bit state per clock, then presents the result over a
//             valid/ready handshake. Byte 0 is the most significant byte.
//  Revision : 1.0 - initial release
// ============================================================================
module inv_sub_bytes_iter #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int N     = 16 / LANES;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  // Element 0 of this packed view sits at bits [127:120], matching byte order.
  typedef logic [0:15][7:0] state_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SUB  = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  // AES inverse S-box, entry i at index i.
  localparam logic [0:255][7:0] C_INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  // Reject lane counts that do not divide the state evenly into powers of two.
  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("inv_sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
  end

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  state_t             wr_q, wr_d;

  logic [3:0]         lane_idx [LANES];
  logic [7:0]         lane_sub [LANES];

  // One inverse S-box per lane, fed from the byte group selected by cnt.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_idx[l] = 4'(int'(cnt_q) * LANES + l);
    assign lane_sub[l] = C_INV_SBOX[wr_q[lane_idx[l]]];
  end

  assign out_state = wr_q;
  assign out_valid = (state_q == S_HOLD);
  assign busy      = (state_q != S_IDLE);

  // Next-state, counter and work-register update; in_ready depends only on
  // registered state (and out_ready while holding a result).
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_d     = wr_q;
    in_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = !rst;
        if (in_valid && !rst) begin
          wr_d    = in_state;
          cnt_d   = '0;
          state_d = S_SUB;
        end
      end
      S_SUB: begin
        for (int l = 0; l < LANES; l++) begin
          wr_d[lane_idx[l]] = lane_sub[l];
        end
        if (cnt_q == CNT_W'(N - 1)) begin
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HOLD: begin
        in_ready = out_ready && !rst;
        if (out_ready) begin
          if (in_valid) begin
            wr_d    = in_state;
            cnt_d   = '0;
            state_d = S_SUB;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset that discards any in-flight block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wr_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inv_sub_bytes_iter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_inv_sub_bytes_iter
//  Brief    : Self-checking bench for inv_sub_bytes_iter. Five instances with
//             LANES = 1, 2, 4, 8, 16 share one stimulus; the LANES=4 instance
//             is used for the handshake and reset sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_inv_sub_bytes_iter;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [127:0] in_state;
  logic         out_ready;

  logic         rdy  [5];
  logic         ov   [5];
  logic [127:0] os   [5];
  logic         bsy  [5];

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 5; k++) begin : g_dut
    inv_sub_bytes_iter #(.LANES(1 << k)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (rdy[k]),
      .in_state  (in_state),
      .out_valid (ov[k]),
      .out_ready (out_ready),
      .out_state (os[k]),
      .busy      (bsy[k])
    );
  end

  typedef struct {
    logic [127:0] din;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_state = '0;
    @(posedge clk); @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Waits (bounded) for the LANES=4 instance to raise out_valid; lat = edges.
  task automatic wait_valid(output int lat);
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (ov[2]) begin
        lat = c;
        break;
      end
    end
  endtask

  int           lat [5];
  logic [127:0] res [5];
  int           l4;
  logic [127:0] held;

  initial begin
    vecs[0] = '{{16{8'h63}}, 128'h0};
    vecs[1] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h52096ad53036a538bf40a39e81f3d7fb};
    vecs[2] = '{{16{8'hff}}, {16{8'h7d}}};
    vecs[3] = '{{16{8'h7c}}, {16{8'h01}}};
    vecs[4] = '{{16{8'h00}}, {16{8'h52}}};

    rst = 1'b1; in_valid = 1'b0; in_state = '0; out_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    // Reset state
    check("rst_out_valid", 128'(ov[2]), 128'h0);
    check("rst_busy", 128'(bsy[2]), 128'h0);
    check("rst_out_state", os[2], 128'h0);
    check("rst_in_ready", 128'(rdy[2]), 128'h0);
    @(negedge clk); rst = 1'b0;
    #1 check("idle_in_ready", 128'(rdy[2]), 128'h1);

    // Table-driven: each vector through every lane count, latency and result.
    for (int v = 0; v < 5; v++) begin
      for (int k = 0; k < 5; k++) begin lat[k] = -1; res[k] = 'x; end
      @(negedge clk);
      in_valid = 1'b1; in_state = vecs[v].din;
      @(posedge clk); #1;
      in_valid = 1'b0; in_state = '0;
      for (int c = 1; c <= 20; c++) begin
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
          if (ov[k] && lat[k] < 0) begin
            lat[k] = c; res[k] = os[k];
          end
        end
      end
      for (int k = 0; k < 5; k++) begin
        check($sformatf("v%0d_lanes%0d_latency", v, 1 << k), 128'(lat[k]), 128'(16 >> k));
        check($sformatf("v%0d_lanes%0d_result", v, 1 << k), res[k], vecs[v].exp);
      end
    end

    // Backpressure: result held stable for 5 cycles, then one handshake to IDLE.
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_state = vecs[1].din;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(l4);
    check("bp_latency", 128'(l4), 128'd4);
    held = os[2];
    check("bp_result", held, vecs[1].exp);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("bp_valid_held", 128'(ov[2]), 128'h1);
      check("bp_state_held", os[2], vecs[1].exp);
      check("bp_in_ready", 128'(rdy[2]), 128'h0);
    end
    @(negedge clk); out_ready = 1'b1;
    #1 check("bp_ready_follow", 128'(rdy[2]), 128'h1);
    @(posedge clk); #1;
    check("bp_after_valid", 128'(ov[2]), 128'h0);
    check("bp_after_busy", 128'(bsy[2]), 128'h0);
    check("bp_wr_retained", os[2], vecs[1].exp);

    // Back-to-back with in_valid held high: second block accepted in HOLD.
    do_reset();
    in_valid = 1'b1; in_state = {16{8'hff}};
    @(posedge clk); #1;
    in_state = {16{8'h7c}};
    wait_valid(l4);
    check("b2b_first_latency", 128'(l4), 128'd4);
    check("b2b_first_result", os[2], {16{8'h7d}});
    check("b2b_hold_in_ready", 128'(rdy[2]), 128'h1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("b2b_overlap_valid", 128'(ov[2]), 128'h0);
    check("b2b_overlap_busy", 128'(bsy[2]), 128'h1);
    wait_valid(l4);
    check("b2b_second_latency", 128'(l4), 128'd4);
    check("b2b_second_result", os[2], {16{8'h01}});
    @(posedge clk); #1;
    check("b2b_end_idle", 128'(bsy[2]), 128'h0);

    // Reset during the second SUB cycle aborts the block.
    do_reset();
    in_valid = 1'b1; in_state = vecs[3].din;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1 check("midsub_in_ready_rst", 128'(rdy[2]), 128'h0);
    @(posedge clk); #1;
    check("midsub_valid", 128'(ov[2]), 128'h0);
    check("midsub_busy", 128'(bsy[2]), 128'h0);
    check("midsub_state", os[2], 128'h0);
    @(negedge clk); rst = 1'b0;
    l4 = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (ov[2]) l4++;
    end
    check("midsub_no_result", 128'(l4), 128'h0);
    @(negedge clk);
    in_valid = 1'b1; in_state = vecs[1].din;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(l4);
    check("midsub_fresh_latency", 128'(l4), 128'd4);
    check("midsub_fresh_result", os[2], vecs[1].exp);

    // Reset while holding a result under backpressure.
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_state = vecs[2].din;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(l4);
    check("holdrst_latency", 128'(l4), 128'd4);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("holdrst_valid", 128'(ov[2]), 128'h0);
    check("holdrst_state", os[2], 128'h0);
    @(negedge clk); rst = 1'b0; out_ready = 1'b1;
    l4 = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (ov[2]) l4++;
    end
    check("holdrst_no_valid", 128'(l4), 128'h0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/inv_sub_bytes_iter.md
# inv_sub_bytes_iter

Iterative InvSubBytes stage for the AES decryption datapath. It accepts a 128-bit state from the InvShiftRows stage and applies the inverse S-box to all 16 bytes, LANES bytes per clock, using LANES instances of the team's combinational 8-bit inverse S-box table. The result goes to the AddRoundKey stage over a valid/ready handshake. LANES trades area against latency.

## Interface
- LANES, default 4: bytes substituted per cycle. Legal values are 1, 2, 4, 8 and 16; any other value is an elaboration error.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  upstream has a state on in_state.
- in_ready  out  1  block can accept a state this cycle.
- in_state  in  128  input state; byte i = bits [127-8i -: 8] (byte 0 is the MSB byte).
- out_valid  out  1  out_state holds a completed result.
- out_ready  in  1  downstream accepts out_state this cycle.
- out_state  out  128  substituted state, same byte ordering as in_state.
- busy  out  1  high in SUB or HOLD.

## Operation
- N = 16/LANES. Byte-group counter cnt is log2(N) bits wide, minimum 1 bit, and counts 0..N-1.
- Work register wr[127:0] drives out_state directly.
- Accept condition: in_valid && in_ready, sampled on the rising edge. in_state is captured into wr only on an accept; changes to in_state at any other time are ignored.
- FSM has three states:
  - IDLE:
    - in_ready=1, out_valid=0.
    - On accept: wr<=in_state, cnt<=0, go to SUB.
  - SUB:
    - in_ready=0, out_valid=0.
    - Each cycle, bytes cnt*LANES .. cnt*LANES+LANES-1 of wr are replaced by their inverse S-box values. Other bytes hold.
    - If cnt==N-1, go to HOLD. Otherwise cnt<=cnt+1.
  - HOLD:
    - out_valid=1, in_ready=out_ready.
    - If out_ready && in_valid: output is consumed and the new state is accepted in the same cycle. wr<=in_state, cnt<=0, go to SUB.
    - If out_ready && !in_valid: go to IDLE. wr retains its value.
    - If !out_ready: stay in HOLD. wr and out_state are held bit-stable.
- busy = (state != IDLE).
- No byte is substituted twice. cnt never exceeds N-1.

## Timing
- Reset, while rst=1 at a rising edge:
  - state=IDLE, cnt=0, wr=0, out_valid=0, busy=0.
  - in_ready is forced to 0 during any cycle in which rst is high.
- Reset mid-operation (SUB or HOLD) aborts the operation. The in-flight state is discarded and no out_valid pulse follows.
- Latency: for an accept at edge E0, out_valid rises after edge EN.
  - LANES=4: out_valid first high 4 cycles after the accept edge.
  - LANES=16: 1 cycle after the accept edge.
- Throughput with out_ready held high and in_valid held high: one state per N+1 cycles, using the HOLD-cycle overlap.
- out_valid is never deasserted without a handshake (out_valid && out_ready). The only exception is reset.
- in_ready and out_valid are derived from registered state only, plus out_ready in HOLD. There is no combinational path from in_valid to in_ready.

## Test plan
- All bytes 0x63, LANES=4, out_ready=1 -> out_valid rises 4 cycles after accept, out_state = 128'h0. With LANES=1 the same stimulus gives a 16-cycle latency.
- in_state = 128'h000102030405060708090a0b0c0d0e0f -> out_state = 128'h52096ad53036a538bf40a39e81f3d7fb, checked for LANES of 1, 2, 4, 8 and 16.
- Backpressure: out_ready=0 for 5 cycles after out_valid rises -> out_valid stays 1, out_state stays stable, in_ready=0. Raising out_ready alone gives one handshake, then IDLE.
- Back-to-back input: in_state=128'hff...ff then 128'h7c...7c with in_valid always high and out_ready=1 -> results all-0x7d, then all-0x01. The second block is accepted in the HOLD cycle of the first.
- Reset mid-SUB: assert rst during the 2nd SUB cycle (LANES=4) -> next cycle out_valid=0, busy=0, out_state=0. No result emerges; a fresh accept afterwards behaves normally.
- Reset in HOLD with out_ready=0 -> out_valid drops on the next edge, with no handshake counted.
